mem_wb_stage: RTL
=================

# mem_wb_stage

Pipeline register and write-back stage directly downstream of the memory stage in the five-stage RV32I core. Captures the memory stage's ALU result, load data, control word and address-range exception flag. Selects the register-file write data and drives the register-file write port. Owns the data-memory exception sequence: it captures the faulting address and PC, issues a one-cycle pipeline flush, and holds the exception until software/control acknowledges it.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-high reset (asserted = 1, sampled on clk rising edge)
- stall  in  1  hold all pipeline registers this cycle
- flush  in  1  load a bubble this cycle (valid cleared)
- valid_in  in  1  instruction present from memory stage
- control_in  in  control_type  control word from memory stage (mem_read, mem_write, mem_to_reg, reg_write, write_reg, funct3)
- pc_in  in  DATA_W  PC of instruction in memory stage
- alu_data_in  in  DATA_W  ALU result / effective address
- memory_data_in  in  DATA_W  truncated, extended load data
- exception_in  in  1  memory-stage address-range flag
- exc_ack  in  1  exception acknowledge
- reg_write_out  out  1  register-file write enable
- write_reg_out  out  REG_ADDR_W  destination register
- write_data_out  out  DATA_W  write-back data
- pipe_flush_out  out  1  one-cycle flush request to upstream stages
- exc_pending  out  1  exception captured, awaiting ack
- exc_addr  out  DATA_W  faulting effective address
- exc_pc  out  DATA_W  faulting instruction PC

## Operation
- Accept = valid_in & ~stall & ~flush.
- Exception qualify: exc_hit = accept & exception_in & (mem_read | mem_write) & state==EXC_IDLE.
- Non-memory instructions never raise an exception, whatever exception_in is.
- Write-back mux: mem_to_reg ? memory_data_in : alu_data_in, registered.
- reg_write_out = registered valid & reg_write & ~squash & (write_reg != 0).
- x0 writes are always suppressed.
- Squash: the faulting instruction, and every instruction accepted while state != EXC_IDLE, registers with valid=0.
- FSM states and transitions:
  - EXC_IDLE: on exc_hit, capture exc_addr = alu_data_in and exc_pc = pc_in, then go to EXC_FLUSH.
  - EXC_FLUSH: pipe_flush_out=1 for exactly this cycle, then go unconditionally to EXC_WAIT.
  - EXC_WAIT: on exc_ack, go to EXC_IDLE. exception_in is ignored in this state.
- exc_ack in EXC_IDLE or EXC_FLUSH is ignored.
- exc_pending = (state != EXC_IDLE).
- exc_addr and exc_pc hold their captured values until the next capture.
- Stall: pipeline registers hold. The FSM still advances (FLUSH→WAIT, WAIT→IDLE on ack).
- Flush and stall together: flush wins, so a bubble is loaded.
- Flush together with exc_hit input conditions: no capture, because accept=0.
- Reset mid-sequence: FSM returns to EXC_IDLE and every output clears next cycle.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on write-back outputs after edge N.
- Exception sampled at edge N:
  - after edge N: exc_pending=1, pipe_flush_out=1
  - after edge N+1: pipe_flush_out=0, exc_pending stays 1
- exc_ack sampled at edge M in EXC_WAIT: exc_pending=0 after edge M. The instruction accepted at edge M is still squashed.
- Reset values: reg_write_out=0, write_reg_out=0, write_data_out=0, pipe_flush_out=0, exc_pending=0, exc_addr=0, exc_pc=0. FSM resets to EXC_IDLE. Retire counter resets to 0.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - Adds output retire_count (64 bits).
  - Increments by 1 on each edge where an accepted, non-squashed instruction registers, including those with reg_write=0.
  - Wraps modulo 2^64.
  - Holds during stall.
- Undefined: the port and counter do not exist. No other behaviour changes.

## Structure
- Shared core package: control_type struct, exc_state_t enum (EXC_IDLE, EXC_FLUSH, EXC_WAIT), DATA_W and REG_ADDR_W constants.
- One sub-module, wb_exc_ctrl: the exception FSM plus the exc_addr/exc_pc capture registers.
- The top level holds the pipeline register, the write-back mux and the optional counter.

## Test plan
- Load: mem_to_reg=1, reg_write=1, write_reg=5, memory_data_in=0xDEADBEEF, alu_data_in=0x10 → next cycle reg_write_out=1, write_reg_out=5, write_data_out=0xDEADBEEF.
- ALU op writing x0: reg_write=1, write_reg=0, alu_data_in=0x1234 → reg_write_out=0.
- Store at alu_data_in=0x200, pc_in=0x40, exception_in=1 → next cycle exc_pending=1, pipe_flush_out=1, exc_addr=0x200, exc_pc=0x40. Then pipe_flush_out=0; following loads are squashed until exc_ack; exc_pending=0 after the ack edge.
- ADD with exception_in=1 (no mem access) → no exception; normal write-back of alu_data_in.
- stall=1 for 3 cycles with changing inputs → outputs hold. stall=1 with flush=1 → bubble (reg_write_out=0).
- Reset asserted during EXC_WAIT → all outputs 0 next cycle. With WB_RETIRE_COUNT_EN: 4 accepted instructions after reset → retire_count=4.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared core types for the MEM/WB stage: control word, exception FSM states, widths.
// Imported by mem_wb_stage and wb_exc_ctrl.
package mem_wb_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [2:0]            funct3;
    } control_type;

    typedef enum logic [1:0] {
        EXC_IDLE  = 2'd0,
        EXC_FLUSH = 2'd1,
        EXC_WAIT  = 2'd2
    } exc_state_t;

    // Only loads and stores can fault on an address-range check.
    function automatic logic is_mem_access(input control_type ctrl);
        return ctrl.mem_read | ctrl.mem_write;
    endfunction

endpackage

// File: rtl/mem_wb_stage_exc_ctrl.sv
// Data-memory exception sequencer: IDLE -> FLUSH (one-cycle flush pulse) -> WAIT until ack.
// Latency: capture and flush pulse visible one cycle after the faulting edge; no backpressure, stall does not freeze it.
// Backpressure: none; exc_ack outside EXC_WAIT is ignored.
module wb_exc_ctrl #(
    parameter int DATA_W = mem_wb_stage_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exc_req,
    input  logic              exc_ack,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic              exc_hit,
    output logic              exc_pending,
    output logic              pipe_flush_out,
    output logic [DATA_W-1:0] exc_addr,
    output logic [DATA_W-1:0] exc_pc
);
    import mem_wb_stage_pkg::*;

    exc_state_t state;
    exc_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= EXC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        exc_hit        = 1'b0;
        exc_pending    = 1'b1;
        pipe_flush_out = 1'b0;
        case (state)
            EXC_IDLE: begin
                exc_pending = 1'b0;
                exc_hit     = exc_req;
                if (exc_req) begin
                    state_nxt = EXC_FLUSH;
                end
            end
            EXC_FLUSH: begin
                pipe_flush_out = 1'b1;
                state_nxt      = EXC_WAIT;
            end
            EXC_WAIT: begin
                // New faults are not observed here; the first one owns the sequence.
                if (exc_ack) begin
                    state_nxt = EXC_IDLE;
                end
            end
            default: begin
                state_nxt = EXC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            exc_addr <= '0;
            exc_pc   <= '0;
        end else if (exc_hit) begin
            exc_addr <= addr_in;
            exc_pc   <= pc_in;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back mux and data-memory exception owner (optional WB_RETIRE_COUNT_EN retire counter).
// Latency: 1 cycle from memory-stage inputs to register-file write port.
// Backpressure: stall holds the pipeline register (FSM keeps running); flush loads a bubble and wins over stall.
module mem_wb_stage #(
    parameter int DATA_W     = mem_wb_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_stage_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          valid_in,
    input  mem_wb_stage_pkg::control_type control_in,
    input  logic [DATA_W-1:0]             pc_in,
    input  logic [DATA_W-1:0]             alu_data_in,
    input  logic [DATA_W-1:0]             memory_data_in,
    input  logic                          exception_in,
    input  logic                          exc_ack,
    output logic                          reg_write_out,
    output logic [REG_ADDR_W-1:0]         write_reg_out,
    output logic [DATA_W-1:0]             write_data_out,
    output logic                          pipe_flush_out,
    output logic                          exc_pending,
    output logic [DATA_W-1:0]             exc_addr,
    output logic [DATA_W-1:0]             exc_pc
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0]                   retire_count
`endif
);
    import mem_wb_stage_pkg::*;

    logic              accept;
    logic              exc_req;
    logic              exc_hit;
    logic              squash_in;
    logic [DATA_W-1:0] wb_data;

    logic                  valid_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     write_data_q;

    // funct3 is carried for the memory stage only; write-back has no use for it.
    logic unused_funct3;
    assign unused_funct3 = ^control_in.funct3;

    assign accept  = valid_in & ~stall & ~flush;
    assign exc_req = accept & exception_in & is_mem_access(control_in);
    assign wb_data = control_in.mem_to_reg ? memory_data_in : alu_data_in;

    // The faulting instruction and everything behind it until ack never retire.
    assign squash_in = exc_hit | exc_pending;

    wb_exc_ctrl #(
        .DATA_W (DATA_W)
    ) u_exc_ctrl (
        .clk            (clk),
        .reset_n        (reset_n),
        .exc_req        (exc_req),
        .exc_ack        (exc_ack),
        .addr_in        (alu_data_in),
        .pc_in          (pc_in),
        .exc_hit        (exc_hit),
        .exc_pending    (exc_pending),
        .pipe_flush_out (pipe_flush_out),
        .exc_addr       (exc_addr),
        .exc_pc         (exc_pc)
    );

    always_ff @(posedge clk) begin
        if (reset_n || flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (!stall) begin
            valid_q      <= valid_in & ~squash_in;
            reg_write_q  <= control_in.reg_write;
            write_reg_q  <= control_in.write_reg;
            write_data_q <= wb_data;
        end
    end

    assign reg_write_out  = valid_q & reg_write_q & (write_reg_q != '0);
    assign write_reg_out  = write_reg_q;
    assign write_data_out = write_data_q;

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            retire_count <= '0;
        end else if (accept && !squash_in) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

endmodule
